spart_rx: RTL and testbench
===========================

# spart_rx

Serial receive half of the SPART. Samples the asynchronous `rxd` line using a 16x oversampling enable from the SPART baud generator, and deframes 8N1 characters (start, 8 data bits LSB first, stop). Presents each received byte to the bus interface with a receive-data-available flag, plus framing and overrun error flags. It is the far-end consumer of the serial stream that the SPART transmitter drives.

## Interface

Parameters:
- `OVERSAMPLE`, default 16: `rate_en` pulses per bit period. Must be a power of two, at least 8.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous and active-low.
- `iocs`  in  1  I/O chip select.
- `iorw`  in  1  1 = read, 0 = write.
- `ioaddr`  in  2  register select; `2'b00` = data transfer register.
- `rate_en`  in  1  one-cycle pulse at `OVERSAMPLE` x baud.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx2bus`  out  8  last received byte.
- `rda`  out  1  receive data available.
- `ferr`  out  1  framing error for the last byte (stop bit sampled low).
- `oerr`  out  1  overrun: a byte was completed while `rda` was still set.

## Operation

- `rxd` passes through a 2-flop synchronizer (`rxs`). Both flops reset to 1. All decisions below use `rxs`.
- Counters:
  - `smp_cnt` is log2(`OVERSAMPLE`) bits wide. It advances only on `rate_en`.
  - `bit_cnt` is 3 bits wide.
  - The shift register is 8 bits; each new bit enters at the MSB and the register shifts right.
- Four-state machine. Every transition below requires `rate_en`; with `rate_en` low the state holds.
  - IDLE: if `rxs`==0, go to START and clear `smp_cnt`.
  - START: increment `smp_cnt`. At `smp_cnt`==`OVERSAMPLE`/2-1 (mid start bit):
    - if `rxs`==0, go to DATA and clear `smp_cnt` and `bit_cnt`;
    - otherwise go back to IDLE. This is a false start; no flags change.
  - DATA: increment `smp_cnt`. At `smp_cnt`==`OVERSAMPLE`-1 (mid data bit), shift `rxs` into the MSB and clear `smp_cnt`.
    - if `bit_cnt`==7, go to STOP;
    - otherwise increment `bit_cnt`.
  - STOP: increment `smp_cnt`. At `smp_cnt`==`OVERSAMPLE`-1 (mid stop bit), in the same cycle:
    - load `rx2bus` with the shift register;
    - set `rda`;
    - set `ferr` to ~`rxs`;
    - set `oerr` if `rda` was 1 and is not being cleared in this cycle;
    - go to IDLE.
- A byte with a framing error is still delivered (`rda`=1, `ferr`=1). `ferr` is rewritten on every completed frame.
- Bus read: when `iocs` & `iorw` & (`ioaddr`==`2'b00`) are all true in a cycle, `rda` and `oerr` clear on the next edge. Reads of other addresses and all writes are ignored.
- Simultaneous bus read and frame completion: the set wins. `rda`=1, `oerr` is unchanged, and `rx2bus` takes the new byte.
- Continuous low line (break): each frame completes with `ferr`=1 and data 0x00. IDLE then restarts on the still-low line.

## Timing

- Reset values: `rx2bus`=0x00, `rda`=0, `ferr`=0, `oerr`=0, state IDLE, `smp_cnt`=0, `bit_cnt`=0, shift register 0x00.
- Asserting reset mid-frame aborts immediately to IDLE and discards partial data. After release, the next falling edge begins a fresh frame.
- Input latency: 2 `clk` cycles from a `rxd` change to `rxs`.
- Start detect: at most one `rate_en` period after `rxs` falls.
- Bit sampling: each bit is sampled at its centre, ±1 `rate_en` period plus the 2-cycle synchronizer delay.
- `rda` rises exactly at the edge that follows the mid-stop-bit `rate_en`. That is about 9.5 bit times after the start edge.
- `rx2bus`, `ferr` and `rda` all update on the same edge. `rx2bus` is stable whenever `rda`=1.
- The receiver can accept back-to-back frames: a new start bit may begin half a bit time after the mid-stop sample.

## Test plan

- Receive 0xA5 at `OVERSAMPLE`=16, `rate_en` every 4 cycles, frame 0 A5 LSB-first 1 → `rx2bus`=0xA5, `rda`=1, `ferr`=0, `oerr`=0. A bus read (iocs=1, iorw=1, ioaddr=00) then clears `rda` on the next edge.
- Glitch: `rxd` low for 4 `rate_en` ticks, then high → machine returns to IDLE; `rda`, `ferr` and `rx2bus` are unchanged.
- Framing error: send 0x3C with stop bit 0 → `rx2bus`=0x3C, `rda`=1, `ferr`=1. A following good frame 0x55 gives `ferr`=0.
- Overrun: send 0x11 then 0x22 back-to-back with no read → `rx2bus`=0x22, `rda`=1, `oerr`=1. A read clears both `rda` and `oerr`.
- Read coinciding with the completion edge of 0x77 → `rda`=1, `oerr`=0, `rx2bus`=0x77.
- Reset mid-frame: assert `rst` low during data bit 3, release, then send 0x81 → outputs are all at reset values during reset; afterwards `rx2bus`=0x81 with no error flags.

Source files
------------

// File: rtl/spart_rx_if.sv
// Bus-side signals of the SPART receiver: register select in, receive data and
// status flags out.
interface spart_rx_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx2bus;
  logic       rda;
  logic       ferr;
  logic       oerr;

  modport master (
    output iocs, iorw, ioaddr,
    input  rx2bus, rda, ferr, oerr
  );

  modport slave (
    input  iocs, iorw, ioaddr,
    output rx2bus, rda, ferr, oerr
  );
endinterface

// File: rtl/spart_rx.sv
// SPART serial receiver: synchronizes rxd, finds the start bit with a
// RATE-enable oversampling counter, samples 8N1 characters at bit centres and
// presents the byte with data-available, framing and overrun flags.
module spart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rate_en,
  input  logic       rxd,
  spart_rx_if.slave  bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SMP_HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_FULL_M1 = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_ONE     = SW'(1);
  localparam logic [SW-1:0] SMP_ZERO    = SW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          rx_meta_r, rxs_r;
  logic [SW-1:0] smp_cnt_r, smp_cnt_nxt_s;
  logic [2:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic [7:0]    rx2bus_r, rx2bus_nxt_s;
  logic          rda_r, rda_nxt_s;
  logic          ferr_r, ferr_nxt_s;
  logic          oerr_r, oerr_nxt_s;
  logic          rd_s;

  // A read of the data register acknowledges the byte and the overrun flag.
  assign rd_s = bus.iocs & bus.iorw & (bus.ioaddr == 2'b00);

  assign bus.rx2bus = rx2bus_r;
  assign bus.rda    = rda_r;
  assign bus.ferr   = ferr_r;
  assign bus.oerr   = oerr_r;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rxd;
      rxs_r     <= rx_meta_r;
    end
  end

  // State, counters, shifter and bus-visible registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      smp_cnt_r <= SMP_ZERO;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      rx2bus_r  <= 8'h00;
      rda_r     <= 1'b0;
      ferr_r    <= 1'b0;
      oerr_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      smp_cnt_r <= smp_cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      rx2bus_r  <= rx2bus_nxt_s;
      rda_r     <= rda_nxt_s;
      ferr_r    <= ferr_nxt_s;
      oerr_r    <= oerr_nxt_s;
    end
  end

  // Next-state and datapath: everything advances on rate_en only; a frame
  // completion overrides a same-cycle bus read.
  always_comb begin
    state_nxt_s   = state_r;
    smp_cnt_nxt_s = smp_cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    rx2bus_nxt_s  = rx2bus_r;
    rda_nxt_s     = rda_r & ~rd_s;
    ferr_nxt_s    = ferr_r;
    oerr_nxt_s    = oerr_r & ~rd_s;
    if (rate_en) begin
      case (state_r)
        IDLE: begin
          if (!rxs_r) begin
            state_nxt_s   = START;
            smp_cnt_nxt_s = SMP_ZERO;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          smp_cnt_nxt_s = smp_cnt_r + SMP_ONE;
          if (smp_cnt_r == SMP_HALF_M1) begin
            if (!rxs_r) begin
              state_nxt_s   = DATA;
              smp_cnt_nxt_s = SMP_ZERO;
              bit_cnt_nxt_s = 3'd0;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = START;
          end
        end
        DATA: begin
          smp_cnt_nxt_s = smp_cnt_r + SMP_ONE;
          if (smp_cnt_r == SMP_FULL_M1) begin
            shift_nxt_s   = {rxs_r, shift_r[7:1]};
            smp_cnt_nxt_s = SMP_ZERO;
            if (bit_cnt_r == 3'd7) begin
              state_nxt_s = STOP;
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end
        STOP: begin
          smp_cnt_nxt_s = smp_cnt_r + SMP_ONE;
          if (smp_cnt_r == SMP_FULL_M1) begin
            rx2bus_nxt_s  = shift_r;
            rda_nxt_s     = 1'b1;
            ferr_nxt_s    = ~rxs_r;
            oerr_nxt_s    = rd_s ? oerr_r : (oerr_r | rda_r);
            state_nxt_s   = IDLE;
            smp_cnt_nxt_s = SMP_ZERO;
          end else begin
            state_nxt_s = STOP;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          smp_cnt_nxt_s = SMP_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: drives 8N1 frames on rxd at 16x
// oversampling with rate_en every 4 clocks and compares the bus view against a
// frame-level model of the receiver's flags.
module tb_spart_rx;

  localparam int OS      = 16;
  localparam int DIV     = 4;
  localparam int BIT_CYC = OS * DIV;

  logic clk = 1'b0;
  logic rst;
  logic rate_en;
  logic rxd;
  logic seen;
  int   rate_ph;
  int   total = 0;
  int   bad   = 0;

  // frame-level expectation of the bus view
  logic [7:0] m_data;
  logic       m_rda, m_ferr, m_oerr;

  spart_rx_if bus ();

  spart_rx #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .rst     (rst),
    .rate_en (rate_en),
    .rxd     (rxd),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // free-running oversampling enable, one clock in every DIV, random phase
  initial begin
    rate_en = 1'b0;
    rate_ph = $urandom_range(0, DIV - 1);
    forever begin
      @(negedge clk);
      rate_en = (rate_ph == DIV - 1);
      rate_ph = (rate_ph + 1) % DIV;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".data"}, {24'h0, bus.rx2bus}, {24'h0, m_data});
    check_eq({tag, ".rda"},  {31'h0, bus.rda},    {31'h0, m_rda});
    check_eq({tag, ".ferr"}, {31'h0, bus.ferr},   {31'h0, m_ferr});
    check_eq({tag, ".oerr"}, {31'h0, bus.oerr},   {31'h0, m_oerr});
  endtask

  task automatic hold_line(input logic v, input int cyc);
    rxd = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    hold_line(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) hold_line(d[i], BIT_CYC);
    hold_line(stop, BIT_CYC);
    rxd = 1'b1;
  endtask

  // one delivered character, as seen from the bus
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic rd_same);
    if (!rd_same) m_oerr = m_oerr | m_rda;
    m_rda  = 1'b1;
    m_data = d;
    m_ferr = ~stop;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_frame(d, stop);
    model_frame(d, stop, 1'b0);
  endtask

  task automatic bus_read();
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0;
    m_rda  = 1'b0;
    m_oerr = 1'b0;
  endtask

  // accesses the receiver must ignore: no select, a write, or another address
  task automatic ignored_access();
    case ($urandom_range(0, 2))
      0: begin bus.iocs = 1'b0; bus.iorw = 1'b1; bus.ioaddr = 2'b00; end
      1: begin bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b00; end
      default: begin bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'($urandom_range(1, 3)); end
    endcase
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       prev_stop;
    rst = 1'b0; rxd = 1'b1;
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
    repeat (5) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // basic receive and read-acknowledge
    send_frame(8'hA5, 1'b1);
    check_all("a5");
    bus_read();
    check_all("a5_read");

    // short low glitch is a false start
    hold_line(1'b0, 4 * DIV);
    hold_line(1'b1, 3 * BIT_CYC);
    check_all("glitch");

    // framing error, then a clean frame rewrites ferr (and overruns)
    send_frame(8'h3C, 1'b0);
    check_all("ferr_3c");
    hold_line(1'b1, BIT_CYC);
    send_frame(8'h55, 1'b1);
    check_all("good_55");
    bus_read();

    // back-to-back frames without a read
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_all("overrun");
    bus_read();
    check_all("overrun_read");

    // read held until the completion edge: the set must win
    hold_line(1'b1, 20);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
    seen = 1'b0;
    fork
      drive_frame(8'h77, 1'b1);
      begin
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(negedge clk);
          if (bus.rda) begin
            bus.iocs = 1'b0; bus.iorw = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    bus.iocs = 1'b0; bus.iorw = 1'b0;
    check_eq("coinc_seen", {31'h0, seen}, 32'h1);
    model_frame(8'h77, 1'b1, 1'b1);
    check_all("coinc");

    // reset during data bit 3, then a fresh frame
    d = 8'h5A;
    hold_line(1'b0, BIT_CYC);
    for (int i = 0; i < 3; i++) hold_line(d[i], BIT_CYC);
    hold_line(d[3], BIT_CYC / 2);
    rst = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
    @(negedge clk);
    check_all("mid_rst");
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1);
    check_all("after_rst");

    // randomized frames, reads and ignored accesses
    prev_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      hold_line(1'b1, prev_stop ? $urandom_range(0, 40) : $urandom_range(48, 90));
      case ($urandom_range(0, 2))
        0: bus_read();
        1: begin
          ignored_access();
          check_all("ignored");
        end
        default: ;
      endcase
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      check_all("rand");
      prev_stop = stop;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
